// File: rtl/fetch_ctrl.sv
// Boot-delay / program-load / run sequencer owning the instruction-memory port.
// Optional FETCH_CTRL_RELOAD_EN: loader activity in RUN parks fetch in HOLD for a reload.
module fetch_ctrl #(
    parameter int          BOOT_CYCLES = 4096,
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] RESET_PC    = 32'h00000314
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loader_valid,
    input  logic [ADDR_W-1:0] loader_addr,
    input  logic [31:0]       loader_data,
    input  logic              loader_done,
    output logic              loader_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              pipe_stall_in,
    output logic              fetch_stall,
    output logic              fetch_run,
    output logic              pc_load,
    output logic [31:0]       pc_init,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic [1:0]        state,
    output logic [15:0]       load_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [15:0] BOOT_LAST = 16'(BOOT_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] boot_cnt_reg;
    logic [15:0] load_count_reg;
    logic        pc_load_reg;
    logic        loading;
    logic        write_accept;

`ifdef FETCH_CTRL_RELOAD_EN
    assign loading = (state_reg == ST_LOAD) || (state_reg == ST_HOLD);
`else
    assign loading = (state_reg == ST_LOAD);
`endif
    assign write_accept = loading && loader_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_BOOT;
            boot_cnt_reg   <= 16'd0;
            load_count_reg <= 16'd0;
            pc_load_reg    <= 1'b0;
        end else begin
            pc_load_reg <= 1'b0;
            if (write_accept && (load_count_reg != 16'hFFFF))
                load_count_reg <= load_count_reg + 16'd1;
            case (state_reg)
                ST_BOOT: begin
                    if (boot_cnt_reg == BOOT_LAST) begin
                        boot_cnt_reg <= 16'd0;
                        state_reg    <= ST_LOAD;
                    end else begin
                        boot_cnt_reg <= boot_cnt_reg + 16'd1;
                    end
                end
                ST_LOAD: begin
                    // A write presented alongside done is still accepted above.
                    if (loader_done) begin
                        state_reg   <= ST_RUN;
                        pc_load_reg <= 1'b1;
                    end
                end
`ifdef FETCH_CTRL_RELOAD_EN
                ST_RUN: begin
                    if (loader_valid)
                        state_reg <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (loader_done) begin
                        state_reg   <= ST_RUN;
                        pc_load_reg <= 1'b1;
                    end
                end
`else
                ST_RUN: begin
                    state_reg <= ST_RUN;
                end
`endif
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    always_comb begin
        loader_ready = loading;
        mem_we       = write_accept;
        mem_addr     = '0;
        mem_wdata    = 32'd0;
        if (loading) begin
            mem_addr  = loader_addr;
            mem_wdata = loader_data;
        end else if (state_reg == ST_RUN) begin
            mem_addr = fetch_addr;
        end
    end

    assign fetch_run   = (state_reg == ST_RUN);
    assign fetch_stall = !fetch_run || pipe_stall_in;
    assign pc_load     = pc_load_reg;
    assign pc_init     = RESET_PC;
    assign state       = state_reg;
    assign load_count  = load_count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected memory writes are queued when driven
// and popped when mem_we is observed; all other outputs checked against constants.
module tb_fetch_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              loader_valid = 1'b0;
    logic [ADDR_W-1:0] loader_addr = '0;
    logic [31:0]       loader_data = '0;
    logic              loader_done = 1'b0;
    logic              loader_ready;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              pipe_stall_in = 1'b0;
    logic              fetch_stall;
    logic              fetch_run;
    logic              pc_load;
    logic [31:0]       pc_init;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [1:0]        state;
    logic [15:0]       load_count;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    fetch_ctrl #(
        .BOOT_CYCLES(8),
        .ADDR_W(ADDR_W),
        .RESET_PC(32'h00000314)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .loader_valid(loader_valid),
        .loader_addr(loader_addr),
        .loader_data(loader_data),
        .loader_done(loader_done),
        .loader_ready(loader_ready),
        .fetch_addr(fetch_addr),
        .pipe_stall_in(pipe_stall_in),
        .fetch_stall(fetch_stall),
        .fetch_run(fetch_run),
        .pc_load(pc_load),
        .pc_init(pc_init),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .state(state),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t e;
        loader_valid = 1'b1;
        loader_addr  = a;
        loader_data  = d;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Compare the current cycle's memory port against the scoreboard.
    task automatic check_write();
        wr_t e;
        if (mem_we === 1'b1) begin
            $display("write addr=%0h data=%08h", mem_addr, mem_wdata);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missing_we", 32'(mem_we), 32'd1);
        end else begin
            chk("no_we", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic boot_phase(input logic poke_done);
        for (int i = 0; i < 8; i++) begin
            loader_done = poke_done && (i < 7);
            chk("boot_state", 32'(state), 32'd0);
            chk("boot_stall", 32'(fetch_stall), 32'd1);
            chk("boot_ready", 32'(loader_ready), 32'd0);
            tick();
        end
        loader_done = 1'b0;
        chk("load_entry", 32'(state), 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        boot_phase(1'b0);

        // Load burst of three writes
        for (int i = 0; i < 3; i++) begin
            drive_write(10'(32'h314 + 4 * i), 32'h00000013);
            #2;
            check_write();
            chk("load_ready", 32'(loader_ready), 32'd1);
            chk("load_stall", 32'(fetch_stall), 32'd1);
            tick();
        end
        loader_valid = 1'b0;
        #2;
        check_write();
        chk("load_count3", 32'(load_count), 32'd3);
        chk("still_load", 32'(state), 32'd1);

        // Final write coincident with done
        drive_write(10'h000, 32'hDEADBEEF);
        loader_done = 1'b1;
        #2;
        check_write();
        tick();
        loader_valid = 1'b0;
        loader_done  = 1'b0;
        chk("run_state", 32'(state), 32'd2);
        chk("pc_load_pulse", 32'(pc_load), 32'd1);
        chk("pc_init", pc_init, 32'h00000314);
        chk("run_unstall", 32'(fetch_stall), 32'd0);
        chk("run_fetch_run", 32'(fetch_run), 32'd1);
        chk("load_count4", 32'(load_count), 32'd4);
        tick();
        chk("pc_load_drop", 32'(pc_load), 32'd0);

        // Stall passthrough in RUN
        fetch_addr = 10'h120;
        for (int i = 0; i < 3; i++) begin
            pipe_stall_in = (i != 1);
            #2;
            chk("stall_pass", 32'(fetch_stall), 32'(i != 1));
            chk("run_addr", 32'(mem_addr), 32'h120);
            chk("run_wdata", mem_wdata, 32'd0);
            tick();
        end
        pipe_stall_in = 1'b0;

        // Loader activity in RUN: no write in this cycle in either build
        loader_valid = 1'b1;
        loader_addr  = 10'h3F0;
        loader_data  = 32'hA5A5A5A5;
        #2;
        check_write();
        chk("run_ready", 32'(loader_ready), 32'd0);
        tick();
`ifdef FETCH_CTRL_RELOAD_EN
        chk("hold_state", 32'(state), 32'd3);
        chk("hold_stall", 32'(fetch_stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive_write(10'(32'h200 + 4 * i), 32'h1000 + i);
            #2;
            check_write();
            tick();
        end
        loader_valid = 1'b0;
        loader_done  = 1'b1;
        #2;
        check_write();
        tick();
        loader_done = 1'b0;
        chk("reload_run", 32'(state), 32'd2);
        chk("reload_pc_load", 32'(pc_load), 32'd1);
        chk("reload_count", 32'(load_count), 32'd6);
`else
        loader_valid = 1'b0;
        chk("run_terminal", 32'(state), 32'd2);
        chk("run_count_kept", 32'(load_count), 32'd4);
`endif

        // Async reset mid-LOAD after five writes; done poked during BOOT is ignored
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        boot_phase(1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_write(10'(32'h100 + 4 * i), 32'h50 + i);
            #2;
            check_write();
            tick();
        end
        loader_valid = 1'b0;
        #1;
        chk("count5", 32'(load_count), 32'd5);
        chk("done_not_kept", 32'(state), 32'd1);
        loader_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_count", 32'(load_count), 32'd0);
        chk("async_we", 32'(mem_we), 32'd0);
        chk("async_pc_load", 32'(pc_load), 32'd0);
        loader_valid = 1'b0;

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
